// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: byte-stream command decoder bridging a UART rx/tx byte path to a
// single-word host bus master. Used as a debug/loader master.
//
// Commands (multi-byte fields little-endian):
//   'W' (0x57), AddrWidth/8 address bytes, 4 data bytes  -> reply 'K' (0x4B)
//   'R' (0x52), AddrWidth/8 address bytes                 -> reply 4 read-data bytes
//   Bus error on either                                   -> reply 'E' (0x45)
//
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   rx_valid_i/rx_data_i/rx_ready_o     received byte stream
//   tx_valid_o/tx_data_o/tx_ready_i     response byte stream
//   host_req_o/host_gnt_i               bus request handshake
//   host_addr_o/we_o/be_o/wdata_o       bus request payload (addr word-aligned, be always 4'hF)
//   host_rvalid_i/rdata_i/err_i         bus response
//   busy_o                              parser not idle
module uart_bus_bridge #(
   parameter int unsigned AddrWidth   = 32,
   parameter int unsigned DataWidth   = 32,
   parameter int unsigned ByteTimeout = 500_000
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_valid_i,
   input  logic [7:0]           rx_data_i,
   output logic                 rx_ready_o,
   output logic                 tx_valid_o,
   output logic [7:0]           tx_data_o,
   input  logic                 tx_ready_i,
   output logic                 host_req_o,
   input  logic                 host_gnt_i,
   output logic [AddrWidth-1:0] host_addr_o,
   output logic                 host_we_o,
   output logic [3:0]           host_be_o,
   output logic [DataWidth-1:0] host_wdata_o,
   input  logic                 host_rvalid_i,
   input  logic [DataWidth-1:0] host_rdata_i,
   input  logic                 host_err_i,
   output logic                 busy_o
);

   localparam int unsigned TimerWidth = $clog2(ByteTimeout);
   localparam logic [TimerWidth-1:0] TimerMax = TimerWidth'(ByteTimeout - 1);
   localparam int unsigned AddrBytes = AddrWidth / 8;
   localparam logic [1:0] AddrLast = 2'(AddrBytes - 1);

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StData,
      StBusReq,
      StBusWait,
      StResp
   } state_e;

   state_e                state_q, state_d;
   logic                  write_q, write_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [AddrWidth-1:0]  addr_q, addr_d;
   logic [DataWidth-1:0]  wdata_q, wdata_d;
   logic [TimerWidth-1:0] timer_q, timer_d;
   // Response bytes go out from the low byte; the buffer shifts right on each handshake.
   logic [DataWidth-1:0]  resp_q, resp_d;
   logic [2:0]            resp_left_q, resp_left_d;
   logic                  rx_fire;

   assign rx_fire = rx_valid_i & rx_ready_o;

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      timer_d     = timer_q;
      resp_d      = resp_q;
      resp_left_d = resp_left_q;

      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (rx_fire && (rx_data_i == 8'h57 || rx_data_i == 8'h52)) begin
               write_d = (rx_data_i == 8'h57);
               cnt_d   = '0;
               state_d = StAddr;
            end
         end

         StAddr: begin
            if (rx_fire) begin
               for (int i = 0; i < AddrBytes; i++) begin
                  if (cnt_q == 2'(i)) addr_d[8*i +: 8] = rx_data_i;
               end
               timer_d = '0;
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == AddrLast) begin
                  cnt_d   = '0;
                  state_d = write_q ? StData : StBusReq;
               end
            end else if (timer_q == TimerMax) begin
               state_d = StIdle;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         StData: begin
            if (rx_fire) begin
               for (int i = 0; i < 4; i++) begin
                  if (cnt_q == 2'(i)) wdata_d[8*i +: 8] = rx_data_i;
               end
               timer_d = '0;
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  cnt_d   = '0;
                  state_d = StBusReq;
               end
            end else if (timer_q == TimerMax) begin
               state_d = StIdle;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         StBusReq: begin
            if (host_gnt_i) state_d = StBusWait;
         end

         StBusWait: begin
            if (host_rvalid_i) begin
               state_d = StResp;
               if (host_err_i) begin
                  resp_d      = DataWidth'(8'h45);
                  resp_left_d = 3'd1;
               end else if (write_q) begin
                  resp_d      = DataWidth'(8'h4B);
                  resp_left_d = 3'd1;
               end else begin
                  resp_d      = host_rdata_i;
                  resp_left_d = 3'd4;
               end
            end
         end

         StResp: begin
            // tx_valid_o is high for the whole state, so tx_ready_i alone is the handshake.
            if (tx_ready_i) begin
               resp_d      = resp_q >> 8;
               resp_left_d = resp_left_q - 3'd1;
               if (resp_left_q == 3'd1) state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         write_q     <= 1'b0;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         timer_q     <= '0;
         resp_q      <= '0;
         resp_left_q <= '0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         timer_q     <= timer_d;
         resp_q      <= resp_d;
         resp_left_q <= resp_left_d;
      end
   end

   assign rx_ready_o   = (state_q == StIdle) || (state_q == StAddr) || (state_q == StData);
   assign tx_valid_o   = (state_q == StResp);
   assign tx_data_o    = resp_q[7:0];
   assign host_req_o   = (state_q == StBusReq);
   assign host_addr_o  = {addr_q[AddrWidth-1:2], 2'b00};
   assign host_we_o    = write_q;
   assign host_be_o    = 4'hF;
   assign host_wdata_o = wdata_q;
   assign busy_o       = (state_q != StIdle);

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

- Byte-stream command decoder that sits downstream of the UART receive path and upstream of its transmit path.
- Parses host-PC commands arriving as bytes and issues single-word read/write transactions on the system host bus.
- Returns read data or a write acknowledge as bytes to the UART transmitter.
- Used as a debug/loader master so memory can be loaded without the core running.

## Interface
Parameters:
- AddrWidth, 32, host bus address width (multiple of 8, at most 32)
- DataWidth, 32, host bus data width (fixed at 32)
- ByteTimeout, 500_000, idle clocks between bytes of one command before the parser aborts (at least 2)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- rx_valid_i  in  1  received byte valid
- rx_data_i  in  8  received byte
- rx_ready_o  out  1  bridge accepts rx byte this cycle
- tx_valid_o  out  1  response byte valid
- tx_data_o  out  8  response byte
- tx_ready_i  in  1  transmitter accepts byte
- host_req_o  out  1  bus request
- host_gnt_i  in  1  bus grant
- host_addr_o  out  AddrWidth  word-aligned address (bits [1:0] forced 0)
- host_we_o  out  1  write enable
- host_be_o  out  4  byte enables (always 4'hF)
- host_wdata_o  out  DataWidth  write data
- host_rvalid_i  in  1  response valid
- host_rdata_i  in  DataWidth  read data
- host_err_i  in  1  bus error, qualified by host_rvalid_i
- busy_o  out  1  parser is not in IDLE

## Operation
- Protocol, all multi-byte fields little-endian:
  - Write: 0x57 ('W'), AddrWidth/8 address bytes, 4 data bytes.
  - Read: 0x52 ('R'), AddrWidth/8 address bytes.
- Any other byte seen in IDLE is consumed and ignored.
- FSM states: IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP.
  - IDLE: on 'W' or 'R', latch the command type, clear the byte counter, go to ADDR.
  - ADDR: shift each byte into address byte [cnt]. After the last byte, a write goes to DATA; a read goes to BUS_REQ.
  - DATA: shift each byte into wdata byte [cnt]. After the 4th byte, go to BUS_REQ.
  - BUS_REQ: hold host_req_o=1 and stable addr/we/wdata until host_gnt_i=1, then go to BUS_WAIT. The request drops the cycle after grant.
  - BUS_WAIT: on host_rvalid_i, load the response buffer and go to RESP.
    - Write OK: 1 byte, 0x4B ('K').
    - Read OK: 4 bytes, rdata[7:0] first.
    - host_err_i=1 (read or write): 1 byte, 0x45 ('E').
  - RESP: present buffered bytes in order. Advance on tx_valid_o&tx_ready_i. After the last byte, go to IDLE.
- rx_ready_o=1 only in IDLE, ADDR and DATA. A byte is consumed when rx_valid_i&rx_ready_o.
- Timeout counter:
  - Cleared on every consumed byte and in IDLE.
  - Increments in ADDR and DATA.
  - On reaching ByteTimeout-1, return to IDLE with no bus access and no response. The partial command is discarded.
- No timeout is applied in BUS_REQ, BUS_WAIT or RESP.

## Timing
- Reset values:
  - rx_ready_o=1 (IDLE), tx_valid_o=0, tx_data_o=0, host_req_o=0, host_we_o=0, busy_o=0.
  - host_addr_o=0, host_wdata_o=0, host_be_o=4'hF.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Last command byte consumed at edge N: host_req_o=1 in cycle N+1.
- Grant in cycle G: host_req_o=0 in cycle G+1.
- rvalid in cycle R: tx_valid_o=1 with the first byte in cycle R+1.
- tx_data_o is stable while tx_valid_o=1 and tx_ready_i=0.
- busy_o = (state != IDLE).
- Address wrap: only bits [1:0] are forced to 0 on host_addr_o. There is no increment, so no wrap occurs.
- host_rvalid_i outside BUS_WAIT is ignored. host_gnt_i outside BUS_REQ is ignored.
- Reset mid-command or mid-transaction: immediately return to IDLE and drop all outputs to reset values. An outstanding bus response after reset is ignored.

## Test plan
- Write: bytes 57 00 10 00 00 EF BE AD DE -> one host_req with addr 0x00001000, we=1, wdata 0xDEADBEEF, be F -> tx byte 0x4B.
- Read: bytes 52 04 20 00 00, rdata 0x12345678 -> one request with addr 0x00002004, we=0 -> tx bytes 78 56 34 12 in order.
- Backpressure:
  - host_gnt_i held low 10 cycles: request and addr/we/wdata stay stable throughout.
  - tx_ready_i toggled during a read response: no byte lost or duplicated.
  - rx_ready_o=0 throughout BUS_REQ..RESP.
- Timeout: with ByteTimeout=16, send 52 04 then stall 20 cycles, then 52 08 00 00 00 -> no bus access for the first command; one read at 0x00000008.
- Error and junk:
  - Leading bytes 00 FF 41 are ignored.
  - A write answered with host_err_i=1 -> single tx byte 0x45, and the parser is back in IDLE.
- Reset in BUS_WAIT: assert rst_ni low for 1 cycle, then pulse host_rvalid_i -> no tx byte, busy_o=0, and a following command works normally.
